serial_flag_alu: RTL and testbench

SERIAL_FLAG_ALU -- requirements
Module: serial_flag_alu

---
 rtl/serial_flag_alu.sv | 117 +++++++++++
 tb/tb_serial_flag_alu.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_flag_alu.sv
// Nibble-serial 16-bit add/compare unit with Zero/Neg/Ofl flags.
// One nibble per clock; valid pulses four cycles after a start is accepted.
module serial_flag_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Op,
    output logic        ready,
    output logic        valid,
    output logic [15:0] Result,
    output logic        Zero,
    output logic        Neg,
    output logic        Ofl,
    output logic        err
);

    // state | meaning
    // IDLE  | waiting for start
    // BUSY  | adding one nibble per edge, LSB nibble first
    // DONE  | result and flags valid for one cycle, start accepted again
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        op_q;
    logic        carry_q;
    logic [15:0] result_q;
    logic        zero_q;
    logic        neg_q;
    logic        ofl_q;
    logic        err_q;

    logic        accept;
    logic [3:0]  nib_idx;
    logic [4:0]  nib_sum;
    logic [15:0] result_full;
    logic        ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (cnt_q == 2'd3) state_d = DONE;
            DONE:    state_d = start ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q != BUSY);
        valid = (state_q == DONE);
    end

    assign accept      = start && ready;
    assign nib_idx     = {cnt_q, 2'b00};
    assign nib_sum     = {1'b0, a_q[nib_idx +: 4]} + {1'b0, b_q[nib_idx +: 4]} + {4'b0000, carry_q};
    assign result_full = {nib_sum[3:0], result_q[11:0]};
    // b_q already holds ~B for compare, so one overflow rule covers both ops
    assign ovf         = (a_q[15] == b_q[15]) && (nib_sum[3] != a_q[15]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= 16'h0000;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ofl_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= start && (state_q == BUSY);
            if (accept) begin
                a_q     <= A;
                b_q     <= Op ? B : ~B;
                op_q    <= Op;
                carry_q <= ~Op;
                cnt_q   <= 2'd0;
            end else if (state_q == BUSY) begin
                result_q[nib_idx +: 4] <= nib_sum[3:0];
                carry_q                <= nib_sum[4];
                cnt_q                  <= cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    zero_q <= (result_full == 16'h0000);
                    neg_q  <= op_q ? nib_sum[3] : (nib_sum[3] ^ ovf);
                    ofl_q  <= op_q ? nib_sum[4] : ovf;
                end
            end
        end
    end

    assign Result = result_q;
    assign Zero   = zero_q;
    assign Neg    = neg_q;
    assign Ofl    = ofl_q;
    assign err    = err_q;

endmodule

// File: tb/tb_serial_flag_alu.sv
// Randomized and directed bench for serial_flag_alu against an arithmetic model.
module tb_serial_flag_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Op;
    logic        ready;
    logic        valid;
    logic [15:0] Result;
    logic        Zero;
    logic        Neg;
    logic        Ofl;
    logic        err;

    int total = 0;
    int bad   = 0;

    serial_flag_alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .Op     (Op),
        .ready  (ready),
        .valid  (valid),
        .Result (Result),
        .Zero   (Zero),
        .Neg    (Neg),
        .Ofl    (Ofl),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {Result, Zero, Neg, Ofl} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic op);
        logic [16:0] s;
        logic [15:0] r;
        int          diff;
        logic        v;
        if (op) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[15:0];
            return {r, r == 16'h0, r[15], s[16]};
        end
        diff = int'($signed(a)) - int'($signed(b));
        r    = a - b;
        v    = (diff > 32767) || (diff < -32768);
        return {r, r == 16'h0, diff < 0, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operation, scramble inputs, wait for valid; lat = -1 on timeout.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic op, output int lat);
        start = 1'b1; A = a; B = b; Op = op;
        tick();
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); Op = 1'($urandom);
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; A = 16'h1234; B = 16'h0001; Op = 1'b1;
        #3;
        total++;
        if ({ready, valid, Result, Zero, Neg, Ofl, err} !== {1'b1, 1'b0, 16'h0, 3'b000, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", {ready, valid, Result, Zero, Neg, Ofl, err}, {1'b1, 1'b0, 16'h0, 4'b0000});
        end
        tick(); tick();
        total++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ignores_start ready=%b valid=%b want ready=1 valid=0", ready, valid);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] va [3] = '{16'h0005, 16'h8000, 16'hFFFF};
        logic [15:0] vb [3] = '{16'h0005, 16'h0001, 16'h0001};
        logic        vo [3] = '{1'b0, 1'b0, 1'b1};
        logic [18:0] want [3] = '{{16'h0000, 3'b100}, {16'h7FFF, 3'b011}, {16'h0000, 3'b101}};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vo[i], lat);
            total++;
            if (lat != 4) begin
                bad++;
                $display("FAIL directed%0d_latency got=%0d want=4", i, lat);
            end
            total++;
            if ({Result, Zero, Neg, Ofl} !== want[i]) begin
                bad++;
                $display("FAIL directed%0d_result got=%h want=%h", i, {Result, Zero, Neg, Ofl}, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic        op;
        logic [18:0] want;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a  = (i % 4 == 0) ? {1'($urandom), 15'h0} : 16'($urandom);
            b  = (i % 5 == 0) ? a : 16'($urandom);
            op = 1'($urandom);
            want = model(a, b, op);
            do_op(a, b, op, lat);
            total++;
            if (lat != 4) begin
                bad++;
                $display("FAIL random%0d_latency got=%0d want=4", i, lat);
            end
            total++;
            if ({Result, Zero, Neg, Ofl} !== want) begin
                bad++;
                $display("FAIL random%0d a=%h b=%h op=%b got=%h want=%h", i, a, b, op, {Result, Zero, Neg, Ofl}, want);
            end
            tick();
            total++;
            if (valid !== 1'b0 || ready !== 1'b1) begin
                bad++;
                $display("FAIL random%0d_after_done valid=%b ready=%b want valid=0 ready=1", i, valid, ready);
            end
        end
    endtask

    task automatic test_busy_start();
        int seen = 0;
        start = 1'b1; A = 16'd3; B = 16'd7; Op = 1'b0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; A = 16'h1111; B = 16'h2222; Op = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err !== 1'b1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_err err=%b valid=%b want err=1 valid=0", err, valid);
        end
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_err_width err=%b want=0", err);
        end
        tick();
        total++;
        if (valid !== 1'b1 || {Result, Neg} !== {16'hFFFC, 1'b1}) begin
            bad++;
            $display("FAIL busy_start_original valid=%b result=%h neg=%b want valid=1 result=fffc neg=1", valid, Result, Neg);
        end
        for (int n = 0; n < 8; n++) begin
            tick();
            if (valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL busy_start_second_valid got=%0d pulses want=0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        start = 1'b1; A = 16'h0F0F; B = 16'h0101; Op = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, valid, Result, Zero, Neg, Ofl, err} !== {1'b1, 1'b0, 16'h0, 3'b000, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_outputs got=%h want=%h", {ready, valid, Result, Zero, Neg, Ofl, err}, {1'b1, 1'b0, 16'h0, 4'b0000});
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_no_valid got=%0d pulses want=0", seen);
        end
        do_op(16'h1234, 16'h1234, 1'b0, lat);
        total++;
        if (lat != 4 || {Result, Zero, Neg, Ofl} !== model(16'h1234, 16'h1234, 1'b0)) begin
            bad++;
            $display("FAIL reset_mid_fresh lat=%0d got=%h want lat=4 %h", lat, {Result, Zero, Neg, Ofl}, model(16'h1234, 16'h1234, 1'b0));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [18:0] w1, w2;
        int lat;
        int n2;
        w1 = model(16'h8000, 16'h0001, 1'b0);
        w2 = model(16'h7FFF, 16'h0001, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b0, lat);
        total++;
        if (lat != 4 || {Result, Zero, Neg, Ofl} !== w1) begin
            bad++;
            $display("FAIL b2b_first lat=%0d got=%h want lat=4 %h", lat, {Result, Zero, Neg, Ofl}, w1);
        end
        start = 1'b1; A = 16'h7FFF; B = 16'h0001; Op = 1'b1;
        tick();
        start = 1'b0; A = 16'h0; B = 16'h0; Op = 1'b0;
        total++;
        if (valid !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept valid=%b ready=%b want 0 0", valid, ready);
        end
        n2 = -1;
        for (int n = 1; n <= 12; n++) begin
            if (!valid) begin
                total++;
                if ({Zero, Neg, Ofl} !== w1[2:0]) begin
                    bad++;
                    $display("FAIL b2b_hold_flags cycle=%0d got=%b want=%b", n, {Zero, Neg, Ofl}, w1[2:0]);
                end
            end
            tick();
            if (valid) begin
                n2 = n;
                break;
            end
        end
        total++;
        if (n2 != 4 || {Result, Zero, Neg, Ofl} !== w2) begin
            bad++;
            $display("FAIL b2b_second lat=%0d got=%h want lat=4 %h", n2, {Result, Zero, Neg, Ofl}, w2);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; A = 16'h0; B = 16'h0; Op = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
